// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_access_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    // Halves need even addresses, words (and the reserved size) need 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

    // Byte-enable pattern shared by loads and stores.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return BE_B0 << addr_lo;
            SZ_H:    return addr_lo[1] ? BE_H_HI : BE_H_LO;
            default: return BE_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane select plus sign/zero extension to a full register.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            zero_ext,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/half and extend it.
    always_comb begin
        lane_b = rdata[7:0];
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (addr_lo)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
        endcase
        case (size)
            SZ_B:    data = zero_ext ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    data = zero_ext ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory req/ack port, stalls until completion,
// and presents extended load data plus pass-through fields to MEM/WB.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        Size_i,
    input  logic              Unsigned_i,
    input  logic              RegWrite_i,
    input  logic              Mem2Reg_i,
    input  logic [4:0]        RDaddr_i,
    input  logic [XLEN-1:0]   ALU_data_i,
    input  logic [XLEN-1:0]   WriteData_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              RegWrite_o,
    output logic              Mem2Reg_o,
    output logic [XLEN-1:0]   ReadData_o,
    output logic [XLEN-1:0]   ALU_data_o,
    output logic [4:0]        RDaddr_o,
    output logic              misalign_o,
    output logic              timeout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rbuf_q, rbuf_d;
    logic              abort_q, abort_d;

    logic              memop;
    logic              misaligned;
    logic              req, stall, misalign, tmo, wb_kill;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   rd_data;

    assign memop      = valid_i & (MemRead_i | MemWrite_i);
    assign misaligned = is_misaligned(Size_i, ALU_data_i[1:0]);

    // Lane steering of the load buffer; inputs are frozen while it is consumed.
    mem_access_stage_load_align u_load_align (
        .rdata    (rbuf_q),
        .addr_lo  (ALU_data_i[1:0]),
        .size     (Size_i),
        .zero_ext (Unsigned_i),
        .data     (load_data)
    );

    // State, wait counter, load buffer and abort flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            abort_q <= abort_d;
        end
    end

    // Next state and stage control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rbuf_d   = rbuf_q;
        abort_d  = abort_q;
        req      = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        tmo      = 1'b0;
        wb_kill  = 1'b0;
        rd_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    if (misaligned) begin
                        misalign = 1'b1;
                        wb_kill  = 1'b1;
                    end else begin
                        req     = 1'b1;
                        stall   = 1'b1;
                        abort_d = 1'b0;
                        if (mem_ack_i) begin
                            rbuf_d  = mem_rdata_i;
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            // The issue cycle counts as the first request cycle.
                            cnt_d   = CNT_W'(1);
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (mem_ack_i) begin
                    rbuf_d  = mem_rdata_i;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    rbuf_d  = '0;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                rd_data = MemRead_i ? load_data : '0;
                wb_kill = abort_q;
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port drive; control strobes drop as soon as reset asserts.
    assign mem_req_o   = req & rst_i;
    assign stall_o     = stall & rst_i;
    assign misalign_o  = misalign & rst_i;
    assign timeout_o   = tmo & rst_i;
    assign mem_we_o    = MemWrite_i & mem_req_o;
    assign mem_addr_o  = {ALU_data_i[31:2], 2'b00};
    assign mem_be_o    = byte_enables(Size_i, ALU_data_i[1:0]);

    // Replicate store data across the lanes selected by the byte enables.
    always_comb begin
        mem_wdata_o = WriteData_i;
        case (Size_i)
            SZ_B:    mem_wdata_o = {4{WriteData_i[7:0]}};
            SZ_H:    mem_wdata_o = {2{WriteData_i[15:0]}};
            default: mem_wdata_o = WriteData_i;
        endcase
    end

    assign RegWrite_o = RegWrite_i & valid_i & ~wb_kill;
    assign Mem2Reg_o  = Mem2Reg_i;
    assign RDaddr_o   = RDaddr_i;
    assign ALU_data_o = ALU_data_i;
    assign ReadData_o = rd_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for the MEM stage: loads, stores, alignment, timeout, reset.
module tb_mem_access_stage;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i, MemRead_i, MemWrite_i, Unsigned_i, RegWrite_i, Mem2Reg_i;
    logic [1:0]  Size_i;
    logic [4:0]  RDaddr_i;
    logic [31:0] ALU_data_i, WriteData_i, mem_rdata_i;
    logic        mem_ack_i;
    logic        mem_req_o, mem_we_o, stall_o, RegWrite_o, Mem2Reg_o, misalign_o, timeout_o;
    logic [31:0] mem_addr_o, mem_wdata_o, ReadData_o, ALU_data_o;
    logic [3:0]  mem_be_o;
    logic [4:0]  RDaddr_o;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Size_i      (Size_i),
        .Unsigned_i  (Unsigned_i),
        .RegWrite_i  (RegWrite_i),
        .Mem2Reg_i   (Mem2Reg_i),
        .RDaddr_i    (RDaddr_i),
        .ALU_data_i  (ALU_data_i),
        .WriteData_i (WriteData_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o),
        .RegWrite_o  (RegWrite_o),
        .Mem2Reg_o   (Mem2Reg_o),
        .ReadData_o  (ReadData_o),
        .ALU_data_o  (ALU_data_o),
        .RDaddr_o    (RDaddr_o),
        .misalign_o  (misalign_o),
        .timeout_o   (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one memory op until the stage releases the stall (bounded).
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int ack_lat,
                          input logic [31:0] rdata, output int stalls, output int tmo_cyc,
                          output logic [3:0] be, output logic [31:0] wdat, output logic we,
                          output logic [31:0] rd_out, output logic rw_out, output logic done);
        valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; Size_i = sz; Unsigned_i = uns;
        RegWrite_i = rd; Mem2Reg_i = rd; RDaddr_i = 5'd9; ALU_data_i = addr; WriteData_i = wd;
        stalls = 0; tmo_cyc = -1; done = 1'b0; be = '0; wdat = '0; we = 1'b0;
        rd_out = '0; rw_out = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            mem_ack_i   = (cyc == ack_lat);
            mem_rdata_i = (cyc == ack_lat) ? rdata : 32'hA5A5_A5A5;
            #1;
            if (cyc == 0) begin
                be = mem_be_o; wdat = mem_wdata_o; we = mem_we_o;
            end
            if (timeout_o) tmo_cyc = cyc;
            if (stall_o) stalls++;
            else begin
                rd_out = ReadData_o; rw_out = RegWrite_o; done = 1'b1;
            end
            step();
        end
        valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; Size_i = 2'b10;
        Unsigned_i = 1'b0; RegWrite_i = 1'b0; Mem2Reg_i = 1'b0; RDaddr_i = '0;
        ALU_data_i = '0; WriteData_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, stall_o, misalign_o, timeout_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_req_o, stall_o, misalign_o, timeout_o});
        end
        checks++;
        if (ReadData_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 00000000", ReadData_o);
        end
        step(); step();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        valid_i = 1'b1; RegWrite_i = 1'b1; Mem2Reg_i = 1'b1; RDaddr_i = 5'd17;
        ALU_data_i = 32'hCAFE_0104; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, stall_o, RegWrite_o, Mem2Reg_o, RDaddr_o} !== {1'b0, 1'b0, 1'b1, 1'b1, 5'd17}) begin
            errors++; $display("FAIL passthru_ctrl: got %b expected 001110001", {mem_req_o, stall_o, RegWrite_o, Mem2Reg_o, RDaddr_o});
        end
        checks++;
        if (ALU_data_o !== 32'hCAFE_0104 || ReadData_o !== 32'h0) begin
            errors++; $display("FAIL passthru_data: got alu=%h rd=%h expected cafe0104/00000000", ALU_data_o, ReadData_o);
        end
        valid_i = 1'b0;
        #1;
        checks++;
        if (RegWrite_o !== 1'b0) begin
            errors++; $display("FAIL passthru_invalid_rw: got %b expected 0", RegWrite_o);
        end
        step();
    endtask

    task automatic test_word_load();
        int st, tc; logic [3:0] be; logic [31:0] wd, rd; logic we, rw, dn;
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (!dn || st != 4) begin
            errors++; $display("FAIL word_load_stall: got %0d cycles (done=%b) expected 4", st, dn);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF || rw !== 1'b1) begin
            errors++; $display("FAIL word_load_data: got %h rw=%b expected deadbeef rw=1", rd, rw);
        end
        checks++;
        if (be !== 4'b1111 || we !== 1'b0) begin
            errors++; $display("FAIL word_load_be: got be=%b we=%b expected 1111/0", be, we);
        end
    endtask

    task automatic test_sub_word_loads();
        int st, tc; logic [3:0] be; logic [31:0] wd, rd; logic we, rw, dn;
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (be !== 4'b1000 || rd !== 32'hFFFF_FF80 || st != 1) begin
            errors++; $display("FAIL byte_signed: got be=%b rd=%h stalls=%0d expected 1000/ffffff80/1", be, rd, st);
        end
        run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (rd !== 32'h0000_0080) begin
            errors++; $display("FAIL byte_unsigned: got %h expected 00000080", rd);
        end
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 1, 32'h0000_7F00, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (be !== 4'b0010 || rd !== 32'h0000_007F) begin
            errors++; $display("FAIL byte_lane1: got be=%b rd=%h expected 0010/0000007f", be, rd);
        end
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 2, 32'h80FF_0000, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (be !== 4'b1100 || rd !== 32'hFFFF_80FF || st != 3) begin
            errors++; $display("FAIL half_signed_hi: got be=%b rd=%h stalls=%0d expected 1100/ffff80ff/3", be, rd, st);
        end
        run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 0, 32'h1234_8001, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (be !== 4'b0011 || rd !== 32'h0000_8001) begin
            errors++; $display("FAIL half_unsigned_lo: got be=%b rd=%h expected 0011/00008001", be, rd);
        end
    endtask

    task automatic test_stores();
        int st, tc; logic [3:0] be; logic [31:0] wd, rd; logic we, rw, dn;
        run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 1, 32'h0, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (be !== 4'b1100 || wd !== 32'hABCD_ABCD || we !== 1'b1) begin
            errors++; $display("FAIL half_store: got be=%b wd=%h we=%b expected 1100/abcdabcd/1", be, wd, we);
        end
        checks++;
        if (rd !== 32'h0 || st != 2) begin
            errors++; $display("FAIL half_store_done: got rd=%h stalls=%0d expected 00000000/2", rd, st);
        end
        run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_005A, 0, 32'h0, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (be !== 4'b0010 || wd !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL byte_store: got be=%b wd=%h expected 0010/5a5a5a5a", be, wd);
        end
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0BAD_F00D, 0, 32'h0, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (be !== 4'b1111 || wd !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL word_store: got be=%b wd=%h expected 1111/0badf00d", be, wd);
        end
    endtask

    task automatic test_misalign();
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; Size_i = 2'b10; RegWrite_i = 1'b1;
        ALU_data_i = 32'h0000_0101;
        #1;
        checks++;
        if ({mem_req_o, stall_o, misalign_o, RegWrite_o} !== 4'b0010) begin
            errors++; $display("FAIL misalign_word: got req/stall/mis/rw=%b expected 0010", {mem_req_o, stall_o, misalign_o, RegWrite_o});
        end
        step();
        MemRead_i = 1'b0; MemWrite_i = 1'b1; Size_i = 2'b01; ALU_data_i = 32'h0000_0203;
        #1;
        checks++;
        if ({mem_req_o, misalign_o} !== 2'b01) begin
            errors++; $display("FAIL misalign_half: got req/mis=%b expected 01", {mem_req_o, misalign_o});
        end
        step();
        valid_i = 1'b0; MemWrite_i = 1'b0;
        #1;
        checks++;
        if (misalign_o !== 1'b0) begin
            errors++; $display("FAIL misalign_clear: got %b expected 0", misalign_o);
        end
        step();
    endtask

    task automatic test_timeout();
        int st, tc; logic [3:0] be; logic [31:0] wd, rd; logic we, rw, dn;
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 1000, 32'h0, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (!dn || st != 16 || tc != 15) begin
            errors++; $display("FAIL timeout_pulse: got stalls=%0d tmo_cyc=%0d done=%b expected 16/15/1", st, tc, dn);
        end
        checks++;
        if (rw !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL timeout_wb: got rw=%b rd=%h expected 0/00000000", rw, rd);
        end
        #1;
        checks++;
        if ({mem_req_o, stall_o, timeout_o} !== 3'b000) begin
            errors++; $display("FAIL timeout_idle: got %b expected 000", {mem_req_o, stall_o, timeout_o});
        end
    endtask

    task automatic test_reset_in_wait();
        int st, tc; logic [3:0] be; logic [31:0] wd, rd; logic we, rw, dn;
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; Size_i = 2'b10; RegWrite_i = 1'b1;
        ALU_data_i = 32'h0000_0400; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        step(); step();
        #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, stall_o} !== 2'b00) begin
            errors++; $display("FAIL rst_wait_drop: got req/stall=%b expected 00", {mem_req_o, stall_o});
        end
        step();
        valid_i = 1'b0;
        rst_i = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        step();
        mem_ack_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, stall_o} !== 2'b00 || ReadData_o !== 32'h0) begin
            errors++; $display("FAIL rst_late_ack: got req/stall=%b rd=%h expected 00/00000000", {mem_req_o, stall_o}, ReadData_o);
        end
        step();
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h2222_3333, st, tc, be, wd, we, rd, rw, dn);
        checks++;
        if (st != 1 || rd !== 32'h2222_3333 || rw !== 1'b1) begin
            errors++; $display("FAIL rst_recover: got stalls=%0d rd=%h rw=%b expected 1/22223333/1", st, rd, rw);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_word_load();
        test_sub_word_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage datapath and control between the EX/MEM and MEM/WB pipeline registers. Takes a decoded memory operation from EX/MEM and drives a request/acknowledge data-memory port. Performs byte/half/word lane steering, sign extension and alignment checking. Stalls the pipeline until the access completes, then presents write-back fields for MEM/WB to capture.

Parameters:
TIMEOUT, 16, max cycles waiting for mem_ack_i before abort (>=2)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
valid_i  in  1  EX/MEM holds a live instruction
MemRead_i  in  1  load
MemWrite_i  in  1  store (MemRead_i and MemWrite_i never both 1)
Size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
Unsigned_i  in  1  zero-extend loads when 1
RegWrite_i  in  1  write-back enable from EX/MEM
Mem2Reg_i  in  1  select load data in WB
RDaddr_i  in  5  destination register
ALU_data_i  in  32  ALU result, doubles as memory address
WriteData_i  in  32  store data (rt)
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word-aligned address {ALU_data_i[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated store data
mem_rdata_i  in  32  read data, valid with mem_ack_i
mem_ack_i  in  1  one-cycle completion pulse
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
RegWrite_o  out  1  to MEM/WB
Mem2Reg_o  out  1  to MEM/WB
ReadData_o  out  32  extended load data to MEM/WB
ALU_data_o  out  32  pass-through to MEM/WB
RDaddr_o  out  5  pass-through to MEM/WB
misalign_o  out  1  alignment fault, one cycle
timeout_o  out  1  memory timeout, one cycle

Behaviour:
- Reset (rst_i low, async): state IDLE, wait counter 0, load buffer 0. mem_req_o, stall_o, misalign_o and timeout_o are 0 immediately. An in-flight request is abandoned and a late mem_ack_i is ignored.
- memop = valid_i & (MemRead_i | MemWrite_i).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE:
  - No memop: stall_o=0, mem_req_o=0, outputs pass through, ReadData_o=0.
  - memop and misaligned: no request, stall_o=0, misalign_o=1, RegWrite_o forced 0.
  - memop and aligned: mem_req_o=1 and stall_o=1 this cycle. If mem_ack_i is also high, capture and go DONE; otherwise go WAIT.
- WAIT:
  - mem_req_o=1, stall_o=1, counter increments each cycle. Address, data and enables are stable because EX/MEM is frozen.
  - On mem_ack_i: latch mem_rdata_i into the buffer, clear counter, go DONE.
  - On counter==TIMEOUT-1 with no ack: timeout_o=1, buffer<=0, set abort flag, go DONE.
- DONE: mem_req_o=0, stall_o=0. Outputs are driven from the buffer; MEM/WB captures at this edge and EX/MEM advances. RegWrite_o forced 0 if aborted. Next state IDLE.
- Total MEM occupancy = 2 + ack latency cycles (ack in issue cycle gives 2).
- Store lanes:
  - byte: be = 1<<addr[1:0], wdata = {4{WriteData_i[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{WriteData_i[15:0]}}
  - word: be = 1111
- Load: mem_be_o identical to store encoding; mem_we_o=0. Select byte/half lane by addr[1:0] and sign- or zero-extend to 32 per Unsigned_i. Stores give ReadData_o=0.
- Pass-through fields (Mem2Reg_o, RDaddr_o, ALU_data_o) are combinational from the inputs in every state. RegWrite_o = RegWrite_i & valid_i, except where forced 0.
- mem_ack_i outside WAIT or the issue cycle is ignored.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/DONE), Size codes (SZ_B/SZ_H/SZ_W), lane/byte-enable constants.
- Sub-module load_align: combinational lane select plus sign/zero extension (rdata, addr[1:0], size, unsigned -> 32b).

Test Plan:
- Word load, addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> stall_o high 4 cycles; DONE shows ReadData_o=0xDEADBEEF, RegWrite_o=1.
- Signed byte load, addr 0x103, rdata 0x80FF_0000 -> be=1000, ReadData_o=0xFFFFFF80; Unsigned_i=1 gives 0x00000080.
- Half store, addr 0x202, WriteData 0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1, ReadData_o=0.
- Word load, addr 0x101 -> no mem_req_o, misalign_o one cycle, stall_o=0, RegWrite_o=0.
- No ack for TIMEOUT=16 -> timeout_o pulse in the 16th request cycle, DONE with RegWrite_o=0, back to IDLE.
- rst_i low during WAIT, then late ack -> mem_req_o/stall_o drop immediately, ack ignored, state IDLE.
